uart_frame_packer: RTL and testbench

- Sits between a sample buffer (512-deep FIFO) and uart_tx.
- Replaces the ad-hoc read-edge logic with framed transmission: SYNC, HDR, LEN, PAYLOAD_LEN payload bytes, CHK.
- Starts a frame only when the buffer holds a full payload, so the frame never stalls on an empty buffer.
- The host resynchronises on SYNC and verifies each frame with CHK.

---
 rtl/uart_frame_packer.sv | 148 ++++++++++++++
 tb/tb_uart_frame_packer.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_packer.sv
// uart_frame_packer: drains a sample buffer into uart_tx as framed packets
// SYNC, HDR {ch[2:0], seq[4:0]}, LEN, PAYLOAD_LEN payload bytes, CHK.
// CHK is the 8-bit modular sum of HDR, LEN and payload (SYNC excluded).
`timescale 1ns/1ps

module uart_frame_packer #(
  parameter int unsigned PAYLOAD_LEN = 16,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned CNT_W       = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [2:0]       ch_id,
  input  logic [CNT_W-1:0] buf_count,
  output logic             buf_rd_en,
  input  logic [7:0]       buf_rd_data,
  input  logic             buf_rd_valid,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             frame_busy,
  output logic [15:0]      frames_sent
);

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned SEQ_W    = 5;
  localparam int unsigned CH_W     = 3;
  localparam int unsigned FRAMES_W = 16;

  // Occupancy needed before a frame may start, and the LEN byte value
  localparam logic [CNT_W-1:0]  START_LEVEL = CNT_W'(PAYLOAD_LEN);
  localparam logic [BYTE_W-1:0] LEN_BYTE    = BYTE_W'(PAYLOAD_LEN);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_HDR     = 3'd2,
    ST_LEN     = 3'd3,
    ST_FETCH   = 3'd4,
    ST_WAIT_RD = 3'd5,
    ST_PAYLOAD = 3'd6,
    ST_CHK     = 3'd7
  } state_t;

  state_t              state;
  logic [CH_W-1:0]     hdr_ch;
  logic [SEQ_W-1:0]    seq;
  logic [BYTE_W-1:0]   sum;
  logic [BYTE_W-1:0]   byte_cnt;
  logic                tx_fire_c;
  logic [BYTE_W-1:0]   hdr_byte_c;
  logic [BYTE_W-1:0]   byte_cnt_nxt_c;

  // Byte handshake with uart_tx and derived header/counter values
  assign tx_fire_c      = tx_valid && tx_ready;
  assign hdr_byte_c     = {hdr_ch, seq};
  assign byte_cnt_nxt_c = BYTE_W'(byte_cnt + BYTE_W'(1));

  // Frame sequencer: state, running checksum and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      hdr_ch      <= '0;
      seq         <= '0;
      sum         <= '0;
      byte_cnt    <= '0;
      buf_rd_en   <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      frame_busy  <= 1'b0;
      frames_sent <= '0;
    end else begin
      buf_rd_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (enable && (buf_count >= START_LEVEL)) begin
            hdr_ch     <= ch_id;
            frame_busy <= 1'b1;
            tx_data    <= SYNC_BYTE;
            tx_valid   <= 1'b1;
            state      <= ST_SYNC;
          end
        end
        ST_SYNC: begin
          if (tx_fire_c) begin
            tx_data <= hdr_byte_c;
            sum     <= hdr_byte_c;
            state   <= ST_HDR;
          end
        end
        ST_HDR: begin
          if (tx_fire_c) begin
            tx_data <= LEN_BYTE;
            sum     <= BYTE_W'(sum + LEN_BYTE);
            state   <= ST_LEN;
          end
        end
        ST_LEN: begin
          // Read request is raised on entry so it is high for the FETCH cycle only
          if (tx_fire_c) begin
            tx_valid  <= 1'b0;
            byte_cnt  <= '0;
            buf_rd_en <= 1'b1;
            state     <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state <= ST_WAIT_RD;
        end
        ST_WAIT_RD: begin
          if (buf_rd_valid) begin
            tx_data  <= buf_rd_data;
            tx_valid <= 1'b1;
            sum      <= BYTE_W'(sum + buf_rd_data);
            state    <= ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (tx_fire_c) begin
            byte_cnt <= byte_cnt_nxt_c;
            if (byte_cnt_nxt_c == LEN_BYTE) begin
              tx_data <= sum;
              state   <= ST_CHK;
            end else begin
              tx_valid  <= 1'b0;
              buf_rd_en <= 1'b1;
              state     <= ST_FETCH;
            end
          end
        end
        ST_CHK: begin
          if (tx_fire_c) begin
            tx_valid    <= 1'b0;
            frame_busy  <= 1'b0;
            seq         <= SEQ_W'(seq + SEQ_W'(1));
            frames_sent <= FRAMES_W'(frames_sent + FRAMES_W'(1));
            state       <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_packer.sv
// tb_uart_frame_packer: table-driven frames plus corner-case sequences,
// with a byte scoreboard fed by expected frames and drained by tx transfers.
`timescale 1ns/1ps

module tb_uart_frame_packer;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned PLEN  = 4;

  logic             clk;
  logic             rst_n;
  logic             enable;
  logic [2:0]       ch_id;
  logic [CNT_W-1:0] buf_count;
  logic             buf_rd_en;
  logic [7:0]       buf_rd_data;
  logic             buf_rd_valid;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             frame_busy;
  logic [15:0]      frames_sent;

  uart_frame_packer #(
    .PAYLOAD_LEN(PLEN),
    .SYNC_BYTE  (8'hA5),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .ch_id       (ch_id),
    .buf_count   (buf_count),
    .buf_rd_en   (buf_rd_en),
    .buf_rd_data (buf_rd_data),
    .buf_rd_valid(buf_rd_valid),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .frame_busy  (frame_busy),
    .frames_sent (frames_sent)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  typedef struct packed {
    logic        rst_first;
    logic [2:0]  ch;
    logic [31:0] pay;
    logic [7:0]  hdr;
    logic [7:0]  chk;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          rd_pulses = 0;
  int          underflow = 0;
  logic [7:0]  fifo [$];
  logic [7:0]  exp_q [$];
  logic [7:0]  got [$];
  logic [4:0]  exp_seq = '0;
  int          exp_frames = 0;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Buffer model: one-cycle read latency, counts read pulses
  always @(posedge clk) begin
    buf_rd_valid <= 1'b0;
    if (buf_rd_en === 1'b1) begin
      rd_pulses++;
      if (fifo.size() > 0) begin
        buf_rd_data  <= fifo.pop_front();
        buf_rd_valid <= 1'b1;
      end else begin
        underflow++;
      end
    end
  end

  // Occupancy update and tx monitor, away from the active edge
  always @(negedge clk) begin
    buf_count = CNT_W'(fifo.size());
    if (rst_n && tx_valid && tx_ready) begin
      got.push_back(tx_data);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL tx_unexpected: actual 0x%0h required no byte", tx_data);
      end else begin
        check("tx_byte", int'(tx_data), int'(exp_q.pop_front()));
      end
    end
  end

  function automatic logic [7:0] model_chk(input logic [7:0] hdr, input logic [31:0] pay);
    logic [7:0] s;
    s = hdr + 8'(PLEN);
    s = s + pay[31:24];
    s = s + pay[23:16];
    s = s + pay[15:8];
    s = s + pay[7:0];
    return s;
  endfunction

  task automatic push_payload(input logic [31:0] pay);
    fifo.push_back(pay[31:24]);
    fifo.push_back(pay[23:16]);
    fifo.push_back(pay[15:8]);
    fifo.push_back(pay[7:0]);
  endtask

  task automatic expect_frame(input logic [7:0] hdr, input logic [31:0] pay, input logic [7:0] chk);
    exp_q.push_back(8'hA5);
    exp_q.push_back(hdr);
    exp_q.push_back(8'(PLEN));
    exp_q.push_back(pay[31:24]);
    exp_q.push_back(pay[23:16]);
    exp_q.push_back(pay[15:8]);
    exp_q.push_back(pay[7:0]);
    exp_q.push_back(chk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_seq = '0;
    exp_frames = 0;
    @(negedge clk);
  endtask

  task automatic wait_start(input string name);
    int k;
    k = 0;
    while (!frame_busy && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!frame_busy) fail_timeout(name);
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while ((frame_busy || exp_q.size() != 0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    if (frame_busy || exp_q.size() != 0) begin
      fail_timeout(name);
      exp_q.delete();
    end
  endtask

  task automatic run_frame(input logic [2:0] ch, input logic [31:0] pay,
                           input logic [7:0] hdr, input logic [7:0] chk);
    int rd0;
    rd0 = rd_pulses;
    got.delete();
    ch_id = ch;
    push_payload(pay);
    expect_frame(hdr, pay, chk);
    enable = 1'b1;
    wait_start("frame_start");
    enable = 1'b0;
    ch_id = ~ch;
    wait_done("frame_done");
    exp_seq++;
    exp_frames++;
    check("frames_sent", int'(frames_sent), exp_frames);
    check("rd_pulses_per_frame", rd_pulses - rd0, int'(PLEN));
  endtask

  initial begin
    vec_t        tbl [4];
    int          bad;
    int          k;
    int          rd0;
    logic [7:0]  hdr;
    logic [31:0] pay;
    logic [2:0]  ch;

    tbl[0] = '{1'b1, 3'd2, 32'h01020304, 8'h40, 8'h4E};
    tbl[1] = '{1'b1, 3'd0, 32'hFFFFFFFF, 8'h00, 8'h00};
    tbl[2] = '{1'b0, 3'd0, 32'h01010101, 8'h01, 8'h09};
    tbl[3] = '{1'b0, 3'd5, 32'h10203040, 8'hA2, 8'h46};

    rst_n    = 1'b0;
    enable   = 1'b0;
    ch_id    = 3'd0;
    tx_ready = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_valid", int'(tx_valid), 0);
    check("rst_tx_data", int'(tx_data), 0);
    check("rst_buf_rd_en", int'(buf_rd_en), 0);
    check("rst_frame_busy", int'(frame_busy), 0);
    check("rst_frames_sent", int'(frames_sent), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    // Table of frames with hand-computed HDR and CHK
    for (int i = 0; i < 4; i++) begin
      if (tbl[i].rst_first) do_reset();
      run_frame(tbl[i].ch, tbl[i].pay, tbl[i].hdr, tbl[i].chk);
    end

    // Occupancy one short of a payload must not start a frame
    ch_id = 3'd1;
    rd0 = rd_pulses;
    fifo.push_back(8'h11);
    fifo.push_back(8'h22);
    fifo.push_back(8'h33);
    enable = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx_valid || buf_rd_en || frame_busy) bad++;
    end
    check("short_buffer_idle", bad, 0);
    check("short_buffer_no_reads", rd_pulses - rd0, 0);
    pay = 32'h11223344;
    hdr = {3'd1, exp_seq};
    got.delete();
    expect_frame(hdr, pay, model_chk(hdr, pay));
    fifo.push_back(8'h44);
    k = 0;
    while (!(tx_valid && tx_data == 8'hA5) && k < 3) begin
      @(negedge clk);
      k++;
    end
    check("sync_after_level_reached", int'(tx_valid && tx_data == 8'hA5), 1);
    enable = 1'b0;
    wait_done("short_buffer_done");
    exp_seq++;
    exp_frames++;
    check("frames_sent_short", int'(frames_sent), exp_frames);

    // tx_ready held low across the HDR byte
    ch = 3'd2;
    hdr = {ch, exp_seq};
    pay = 32'h0A0B0C0D;
    got.delete();
    ch_id = ch;
    push_payload(pay);
    expect_frame(hdr, pay, model_chk(hdr, pay));
    tx_ready = 1'b0;
    enable = 1'b1;
    wait_start("stall_start");
    enable = 1'b0;
    @(posedge clk);
    #1 tx_ready = 1'b1;
    @(posedge clk);
    #1 tx_ready = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (!tx_valid || tx_data != hdr) bad++;
    end
    check("stall_hold_hdr", bad, 0);
    check("stall_hdr_value", int'(tx_data), int'(hdr));
    @(posedge clk);
    #1 tx_ready = 1'b1;
    wait_done("stall_done");
    exp_seq++;
    exp_frames++;
    check("frames_sent_stall", int'(frames_sent), exp_frames);
    check("stall_byte_count", got.size(), 8);

    // 33 frames: sequence field wraps on the last one
    do_reset();
    for (int f = 0; f < 33; f++) begin
      ch  = 3'($urandom_range(0, 7));
      pay = $urandom;
      hdr = {ch, exp_seq};
      run_frame(ch, pay, hdr, model_chk(hdr, pay));
    end
    if (got.size() >= 2) check("seq_wrap_hdr", int'(got[1][4:0]), 0);
    else fail_timeout("seq_wrap_hdr_missing");
    check("frames_sent_33", int'(frames_sent), 33);

    // Asynchronous reset in the middle of the payload
    ch = 3'd4;
    pay = 32'hDEADBEEF;
    hdr = {ch, exp_seq};
    rd0 = rd_pulses;
    ch_id = ch;
    push_payload(pay);
    expect_frame(hdr, pay, model_chk(hdr, pay));
    enable = 1'b1;
    wait_start("midreset_start");
    enable = 1'b0;
    k = 0;
    while ((rd_pulses - rd0) < 2 && k < 100) begin
      @(negedge clk);
      k++;
    end
    if ((rd_pulses - rd0) < 2) fail_timeout("midreset_reads");
    rst_n = 1'b0;
    #1;
    check("midrst_tx_valid", int'(tx_valid), 0);
    check("midrst_tx_data", int'(tx_data), 0);
    check("midrst_buf_rd_en", int'(buf_rd_en), 0);
    check("midrst_frame_busy", int'(frame_busy), 0);
    check("midrst_frames_sent", int'(frames_sent), 0);
    exp_q.delete();
    fifo.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_seq = '0;
    exp_frames = 0;
    @(negedge clk);
    ch = 3'd6;
    pay = 32'h5A6B7C8D;
    hdr = {ch, exp_seq};
    run_frame(ch, pay, hdr, model_chk(hdr, pay));
    if (got.size() >= 2) begin
      check("post_reset_sync", int'(got[0]), 8'hA5);
      check("post_reset_seq", int'(got[1][4:0]), 0);
    end else begin
      fail_timeout("post_reset_frame_missing");
    end

    // enable dropped after SYNC: frame completes, no new frame starts
    ch = 3'd3;
    pay = 32'h0F1E2D3C;
    hdr = {ch, exp_seq};
    got.delete();
    ch_id = ch;
    push_payload(pay);
    push_payload(32'h99887766);
    expect_frame(hdr, pay, model_chk(hdr, pay));
    enable = 1'b1;
    k = 0;
    while (got.size() < 1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (got.size() < 1) fail_timeout("enable_drop_sync");
    enable = 1'b0;
    wait_done("enable_drop_done");
    exp_seq++;
    exp_frames++;
    check("frames_sent_enable_drop", int'(frames_sent), exp_frames);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (frame_busy || tx_valid || buf_rd_en) bad++;
    end
    check("no_restart_after_enable_drop", bad, 0);
    check("leftover_buffer", fifo.size(), 4);
    fifo.delete();

    check("rd_underflow", underflow, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule
